bcd_counter_n_digit: RTL and testbench

//   Parametrised multi-digit BCD up/down counter.
//   - Successor of the single-digit 0-9 counter.
//   - Adds digit count, a configurable top-digit limit (e.g. 0-59), direction control,

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_cell.sv | 54 +++++
 rtl/bcd_counter_n_digit.sv | 99 +++++++++
 tb/tb_bcd_counter_n_digit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and the load sanitiser used by every digit cell.
//   BCD_MAX / BCD_MIN : legal range of an ordinary decimal digit
//   bcd_sanitise      : maps an out-of-range nibble to zero so that a
//                       parallel load can never leave an illegal digit
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic [3:0] bcd_sanitise(input logic [3:0] nibble,
                                                input logic [3:0] max);
        return (nibble > max) ? BCD_MIN : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with up/down stepping and sanitised load.
//   clk, rst : clock and synchronous active-high reset (digit -> 0)
//   step     : advance this digit one position this cycle
//   up       : 1 = increment, 0 = decrement
//   load     : take ld_val (sanitised against max); beats step
//   ld_val   : nibble to load
//   max      : highest legal value of this digit (9, or the top-digit limit)
//   q        : current digit value
//   at_max   : q equals max (carry-out condition when counting up)
//   at_min   : q equals zero (borrow-out condition when counting down)
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] ld_val,
    input  logic [3:0] max,
    output logic [3:0] q,
    output logic       at_max,
    output logic       at_min
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    assign at_max = (q_q == max);
    assign at_min = (q_q == BCD_MIN);
    assign q      = q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = bcd_sanitise(ld_val, max);
        end else if (step) begin
            if (up) begin
                q_d = at_max ? BCD_MIN : q_q + 4'd1;
            end else begin
                q_d = at_min ? max : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/bcd_counter_n_digit.sv
// Multi-digit BCD up/down counter with limited top digit, parallel load,
// wrap-or-saturate behaviour, cascade terminal count and sticky overflow.
//   clk, rst   : clock and synchronous active-high reset
//   en         : count enable, one step per cycle
//   up         : 1 = increment, 0 = decrement
//   load       : parallel load strobe (beats en)
//   load_value : BCD value to load, nibble i -> digit i
//   clr_ovf    : clear the sticky overflow flag
//   digits     : current count, nibble i = digit i
//   tc         : combinational terminal count for the next stage in a chain
//   ovf        : sticky flag, set whenever a terminal step is taken
module bcd_counter_n_digit
    import bcd_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int TOP_DIGIT_MAX = 9,
    parameter bit WRAP          = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                clr_ovf,
    output logic [4*DIGITS-1:0] digits,
    output logic                tc,
    output logic                ovf
);

    localparam logic [3:0] TOP_MAX      = 4'(TOP_DIGIT_MAX);
    localparam bit         HOLD_AT_TERM = (WRAP == 1'b0);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step;
    logic              terminal;
    logic              advance;
    logic              ovf_q;
    logic              ovf_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam logic [3:0] CELL_MAX = (g == DIGITS - 1) ? TOP_MAX : BCD_MAX;

        bcd_digit_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .step   (step[g]),
            .up     (up),
            .load   (load),
            .ld_val (load_value[4*g +: 4]),
            .max    (CELL_MAX),
            .q      (digits[4*g +: 4]),
            .at_max (at_max[g]),
            .at_min (at_min[g])
        );
    end

    assign terminal = up ? (&at_max) : (&at_min);

    // In saturate mode the whole chain is frozen at the terminal value;
    // in wrap mode every digit carries/borrows and the count rolls over.
    assign advance = en & ~(terminal & HOLD_AT_TERM);

    // Ripple carry/borrow: a digit steps only when every lower digit is at
    // its rollover value in the current direction.
    always_comb begin
        logic carry;
        step  = '0;
        carry = advance;
        for (int i = 0; i < DIGITS; i++) begin
            step[i] = carry;
            carry   = carry & (up ? at_max[i] : at_min[i]);
        end
    end

    assign tc = en & ~load & ~rst & terminal;

    // Set beats clear so a terminal event is never lost to a coincident clear.
    always_comb begin
        ovf_d = ovf_q;
        if (tc) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_counter_n_digit.sv
module tb_bcd_counter_n_digit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [15:0] lv0 = '0;
    logic [7:0]  lv1 = '0;
    logic [7:0]  lv2 = '0;
    logic [15:0] dg0;
    logic [7:0]  dg1;
    logic [7:0]  dg2;
    logic [2:0]  tc_w;
    logic [2:0]  ovf_w;

    // Three configurations share the control inputs.
    bcd_counter_n_digit #(.DIGITS(4), .TOP_DIGIT_MAX(9), .WRAP(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_value(lv0),
        .clr_ovf(clr_ovf), .digits(dg0), .tc(tc_w[0]), .ovf(ovf_w[0]));
    bcd_counter_n_digit #(.DIGITS(2), .TOP_DIGIT_MAX(5), .WRAP(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_value(lv1),
        .clr_ovf(clr_ovf), .digits(dg1), .tc(tc_w[1]), .ovf(ovf_w[1]));
    bcd_counter_n_digit #(.DIGITS(2), .TOP_DIGIT_MAX(9), .WRAP(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_value(lv2),
        .clr_ovf(clr_ovf), .digits(dg2), .tc(tc_w[2]), .ovf(ovf_w[2]));

    int nd[3]   = '{4, 2, 2};
    int ntop[3] = '{9, 5, 9};
    int nwrap[3] = '{1, 1, 0};

    // Reference model: count kept as a plain integer in mixed radix.
    int val[3]   = '{0, 0, 0};
    bit ovf_m[3] = '{0, 0, 0};

    typedef struct packed {
        logic [2:0]       tc;
        logic [2:0]       ovf;
        logic [2:0][15:0] dig;
    } exp_t;

    exp_t sbq[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic int to_val(input logic [15:0] nibs, input int k);
        int v = 0;
        for (int i = 0; i < nd[k]; i++) begin
            int n   = int'(nibs[4*i +: 4]);
            int lim = (i == nd[k] - 1) ? ntop[k] : 9;
            if (n > lim) n = 0;
            v = v + n * pow10(i);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_nibs(input int v, input int k);
        logic [15:0] r = '0;
        for (int i = 0; i < nd[k]; i++) begin
            int d = (i == nd[k] - 1) ? v / pow10(i) : (v / pow10(i)) % 10;
            r[4*i +: 4] = 4'(d);
        end
        return r;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit u, input bit l, input bit c,
                       input logic [15:0] v0 = 16'h0, input logic [7:0] v1 = 8'h0,
                       input logic [7:0] v2 = 8'h0);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; clr_ovf = c;
        lv0 = v0; lv1 = v1; lv2 = v2;
        x = '0;
        for (int k = 0; k < 3; k++) begin
            int  m     = (ntop[k] + 1) * pow10(nd[k] - 1);
            bit  term  = u ? (val[k] == m - 1) : (val[k] == 0);
            bit  t     = e && !l && !r && term;
            logic [15:0] lvk = (k == 0) ? v0 : (k == 1) ? {8'h0, v1} : {8'h0, v2};
            x.tc[k] = t;
            if (r) begin
                val[k] = 0;
            end else if (l) begin
                val[k] = to_val(lvk, k);
            end else if (e) begin
                if (term) begin
                    if (nwrap[k] != 0) val[k] = u ? 0 : m - 1;
                end else begin
                    val[k] = u ? val[k] + 1 : val[k] - 1;
                end
            end
            if (r) ovf_m[k] = 1'b0;
            else if (t) ovf_m[k] = 1'b1;
            else if (c) ovf_m[k] = 1'b0;
            x.ovf[k] = ovf_m[k];
            x.dig[k] = to_nibs(val[k], k);
        end
        sbq.push_back(x);
    endtask

    task automatic chk(input string nm, input int k, input logic [15:0] a, input logic [15:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, a, e, $time);
        end
    endtask

    // Monitor: tc is sampled late in the cycle the stimulus applies to,
    // digits/ovf just after the edge that consumes that stimulus.
    initial begin
        logic [2:0] tc_s;
        exp_t x;
        forever begin
            @(negedge clk);
            #3;
            tc_s = tc_w;
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("digits", 0, dg0, x.dig[0]);
                chk("digits", 1, {8'h0, dg1}, x.dig[1]);
                chk("digits", 2, {8'h0, dg2}, x.dig[2]);
                for (int k = 0; k < 3; k++) begin
                    chk("tc", k, {15'h0, tc_s[k]}, {15'h0, x.tc[k]});
                    chk("ovf", k, {15'h0, ovf_w[k]}, {15'h0, x.ovf[k]});
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        // reset
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        // full up sweep through 9999 -> 0000
        repeat (10005) cyc(0, 1, 1, 0, 0);
        // load 58 and count through 59 -> 00
        cyc(0, 0, 1, 1, 0, 16'h0058, 8'h58, 8'h58);
        repeat (3) cyc(0, 1, 1, 0, 0);
        // out-of-range nibbles load as zero
        cyc(0, 1, 1, 1, 0, 16'h7C7C, 8'h7C, 8'h7C);
        cyc(0, 0, 1, 0, 0);
        // saturate down at zero
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 16'h0001, 8'h01, 8'h01);
        repeat (4) cyc(0, 1, 0, 0, 0);
        // load beats en, then reset mid-count
        cyc(0, 0, 1, 1, 0, 16'h0199, 8'h19, 8'h19);
        cyc(0, 1, 1, 1, 0, 16'h4000, 8'h40, 8'h40);
        repeat (5) cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        // ovf set, cleared, then clear coinciding with a wrap
        cyc(0, 0, 1, 1, 0, 16'h9999, 8'h59, 8'h99);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 1, 0, 16'h9999, 8'h59, 8'h99);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 0);
        // down wrap from zero
        cyc(0, 0, 0, 1, 0, 16'h0000, 8'h00, 8'h00);
        repeat (3) cyc(0, 1, 0, 0, 0);
        // randomized traffic
        repeat (3000) begin
            bit r = ($urandom_range(0, 49) == 0);
            bit e = ($urandom_range(0, 3) != 0);
            bit u = ($urandom_range(0, 1) == 1);
            bit l = ($urandom_range(0, 15) == 0);
            bit c = ($urandom_range(0, 7) == 0);
            logic [15:0] v0 = 16'($urandom);
            logic [7:0]  v1 = 8'($urandom);
            logic [7:0]  v2 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                v0 = u ? 16'h9998 : 16'h0001;
                v1 = u ? 8'h58 : 8'h01;
                v2 = u ? 8'h98 : 8'h01;
            end
            cyc(r, e, u, l, c, v0, v1, v2);
        end
        @(negedge clk);
        en = 1'b0; load = 1'b0; rst = 1'b0; clr_ovf = 1'b0;
        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
